ifetch_pc_gen: RTL and testbench

- Fetch-stage PC generator; sits directly downstream of the pipeline flush controller.
- Consumes its redirect (flush_pc plus a valid) and the branch predictor's guess.
- Holds the architectural fetch PC and drives a single-outstanding SRAM-like instruction request channel.
- Discards in-flight responses made stale by a redirect, and buffers one fetched instruction toward IF/ID with valid/ready backpressure.

---
 rtl/ifetch_pc_gen_pkg.sv | 19 +
 rtl/ifetch_pc_gen_out_buf.sv | 43 ++++
 rtl/ifetch_pc_gen.sv | 128 ++++++++++++
 tb/tb_ifetch_pc_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pc_gen_pkg.sv
// Shared fetch-stage definitions: fetch FSM states, reset vector, widths and
// the exception code raised for a misaligned fetch address.
package ifetch_pc_gen_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  // Exception code reported downstream when out_adef is set.
  localparam logic [5:0] ECODE_ADEF = 6'h08;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_pc_gen_out_buf.sv
// One-entry holding register between fetch and IF/ID with valid/ready
// handshake; a flush empties it regardless of any fill or drain.
module ifetch_out_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fill,
  input  logic [ADDR_WIDTH-1:0] fill_pc,
  input  logic [INST_WIDTH-1:0] fill_inst,
  input  logic                  fill_adef,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  out_adef,
  output logic                  buf_free
);

  assign buf_free = !out_valid || out_ready;

  // Payload is left untouched on drain/flush; only the valid bit matters then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
      out_adef  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fill) begin
      out_valid <= 1'b1;
      out_pc    <= fill_pc;
      out_inst  <= fill_inst;
      out_adef  <= fill_adef;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_pc_gen.sv
// Fetch PC generator: holds the fetch PC, issues one outstanding instruction
// request at a time, drops responses made stale by a redirect.
module ifetch_pc_gen #(
  parameter int                    ADDR_WIDTH = ifetch_pc_gen_pkg::ADDR_WIDTH,
  parameter int                    INST_WIDTH = ifetch_pc_gen_pkg::INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ifetch_pc_gen_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  pred_taken,
  input  logic [ADDR_WIDTH-1:0] pred_target,
  output logic                  inst_req,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_addr_ok,
  input  logic                  inst_data_ok,
  input  logic [INST_WIDTH-1:0] inst_rdata,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  out_adef,
  input  logic                  out_ready
);

  import ifetch_pc_gen_pkg::*;

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] req_pc_next;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic                  pc_aligned;
  logic                  buf_free;
  logic                  fill;
  logic [ADDR_WIDTH-1:0] fill_pc;
  logic [INST_WIDTH-1:0] fill_inst;
  logic                  fill_adef;

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign seq_pc     = pc_q + ADDR_WIDTH'(4);
  assign inst_addr  = pc_q;

  // rst_n gates the request so nothing is issued while reset is held.
  assign inst_req = rst_n && (state == REQ) && buf_free && pc_aligned && !redirect_valid;

  always_comb begin
    state_next  = state;
    pc_next     = pc_q;
    req_pc_next = req_pc;
    fill        = 1'b0;
    fill_pc     = pc_q;
    fill_inst   = '0;
    fill_adef   = 1'b0;
    unique case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end else if (buf_free && !pc_aligned) begin
          fill      = 1'b1;
          fill_adef = 1'b1;
        end else if (inst_req && inst_addr_ok) begin
          req_pc_next = pc_q;
          pc_next     = pred_taken ? pred_target : seq_pc;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = inst_data_ok ? REQ : DROP;
        end else if (inst_data_ok) begin
          fill       = 1'b1;
          fill_pc    = req_pc;
          fill_inst  = inst_rdata;
          state_next = REQ;
        end
      end
      DROP: begin
        // The stale response still has to be swallowed even if another
        // redirect lands on the same cycle.
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end
        if (inst_data_ok) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= REQ;
      pc_q   <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= state_next;
      pc_q   <= pc_next;
      req_pc <= req_pc_next;
    end
  end

  ifetch_out_buf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INST_WIDTH(INST_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .fill      (fill),
    .fill_pc   (fill_pc),
    .fill_inst (fill_inst),
    .fill_adef (fill_adef),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_adef  (out_adef),
    .buf_free  (buf_free)
  );

endmodule

// File: tb/tb_ifetch_pc_gen.sv
// Bench for ifetch_pc_gen: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_ifetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adef;
  logic        out_ready;

  always #5 clk = ~clk;

  ifetch_pc_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_adef       (out_adef),
    .out_ready      (out_ready)
  );

  int compared   = 0;
  int mismatched = 0;

  // Transaction model: fetch PC, one-entry output queue, outstanding/stale flags.
  logic [31:0] m_pc, m_req_pc, m_out_pc, m_out_inst;
  logic        m_valid, m_adef, m_busy, m_stale;

  logic        mem_pending, mem_force, mem_rand_lat;
  int          mem_cnt, mem_lat;
  logic [31:0] mem_data, mem_force_data;

  logic        s_req;
  logic [31:0] s_addr;

  logic        d_rv, d_aok, d_ordy, bp_directed;
  logic [31:0] d_rpc;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h1C00_0000) return 32'h0280_0C21;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic bf, er;
    bf = !m_valid || out_ready;
    er = !m_busy && bf && (m_pc[1:0] == 2'b00) && !redirect_valid;
    checkOutput("inst_req", inst_req, er);
    checkOutput("inst_addr", inst_addr, m_pc);
    checkOutput("out_valid", out_valid, m_valid);
    if (m_valid) begin
      checkOutput("out_pc", out_pc, m_out_pc);
      checkOutput("out_inst", out_inst, m_out_inst);
      checkOutput("out_adef", out_adef, m_adef);
    end
    s_req  = inst_req;
    s_addr = inst_addr;
  endtask

  task automatic modelUpdate();
    logic bf, er;
    bf = !m_valid || out_ready;
    er = !m_busy && bf && (m_pc[1:0] == 2'b00) && !redirect_valid;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (redirect_valid) begin
      m_pc    = redirect_pc;
      m_valid = 1'b0;
      if (m_busy) begin
        if (inst_data_ok) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else if (!m_busy) begin
      if (er && inst_addr_ok) begin
        m_req_pc = m_pc;
        m_pc     = pred_taken ? pred_target : m_pc + 32'd4;
        m_busy   = 1'b1;
        m_stale  = 1'b0;
      end else if (bf && m_pc[1:0] != 2'b00) begin
        m_valid    = 1'b1;
        m_out_pc   = m_pc;
        m_out_inst = 32'h0;
        m_adef     = 1'b1;
      end
    end else if (inst_data_ok) begin
      if (!m_stale) begin
        m_valid    = 1'b1;
        m_out_pc   = m_req_pc;
        m_out_inst = inst_rdata;
        m_adef     = 1'b0;
      end
      m_busy  = 1'b0;
      m_stale = 1'b0;
    end
  endtask

  task automatic memUpdate();
    if (s_req && inst_addr_ok) checkOutput("one_outstanding", mem_pending, 1'b0);
    if (inst_data_ok) mem_pending = 1'b0;
    else if (mem_pending && mem_cnt > 0) mem_cnt--;
    if (s_req && inst_addr_ok) begin
      mem_pending = 1'b1;
      mem_data    = mem_force ? mem_force_data : memWord(s_addr);
      mem_cnt     = mem_rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
      mem_force   = 1'b0;
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelUpdate();
    memUpdate();
    @(negedge clk);
    redirect_valid = d_rv;
    redirect_pc    = d_rpc;
    inst_addr_ok   = d_aok;
    out_ready      = d_ordy;
    if (bp_directed) begin
      pred_taken  = (m_pc == 32'h1C00_0008);
      pred_target = 32'h1C00_0100;
    end else begin
      pred_taken  = ($urandom_range(0, 3) == 0);
      pred_target = 32'h1C00_0000 + ({22'h0, 10'($urandom_range(0, 1023))} << 2);
    end
    inst_data_ok = mem_pending && (mem_cnt == 0);
    inst_rdata   = inst_data_ok ? mem_data : $urandom;
    #1 checkAll();
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 0; redirect_pc = 0; pred_taken = 0; pred_target = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0; out_ready = 0;
    m_pc = RST_PC; m_req_pc = 0; m_out_pc = 0; m_out_inst = 0;
    m_valid = 0; m_adef = 0; m_busy = 0; m_stale = 0;
    mem_pending = 0; mem_force = 0; mem_rand_lat = 0; mem_cnt = 0; mem_lat = 0;
    mem_data = 0; mem_force_data = 0; s_req = 0; s_addr = 0;
    d_rv = 0; d_rpc = 0; d_aok = 1; d_ordy = 1; bp_directed = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_inst_req", inst_req, 1'b0);
    checkOutput("rst_inst_addr", inst_addr, RST_PC);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_inst", out_inst, 32'h0);
    checkOutput("rst_out_adef", out_adef, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus();
    checkOutput("first_req", inst_req, 1'b1);
    checkOutput("first_addr", inst_addr, 32'h1C00_0000);
    applyStimulus();
    checkOutput("next_addr", inst_addr, 32'h1C00_0004);
    applyStimulus();
    checkOutput("first_valid", out_valid, 1'b1);
    checkOutput("first_pc", out_pc, 32'h1C00_0000);
    checkOutput("first_inst", out_inst, 32'h0280_0C21);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("pred_addr", inst_addr, 32'h1C00_0100);
    applyStimulus();
    checkOutput("pred_seq0", out_pc, 32'h1C00_0008);
    applyStimulus();
    applyStimulus();
    checkOutput("pred_seq1", out_pc, 32'h1C00_0100);

    // Redirect right after accepting 0x1C000104; its response is slow and poisoned.
    mem_lat = 3; mem_force = 1; mem_force_data = 32'hDEAD_BEEF;
    d_rv = 1; d_rpc = 32'h1C00_0400;
    applyStimulus();
    checkOutput("redir_wait_req", inst_req, 1'b0);
    d_rv = 0; mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("no_stale", out_valid && (out_inst == 32'hDEAD_BEEF), 1'b0);
      if (i < 3) checkOutput("drop_no_req", inst_req, 1'b0);
    end
    checkOutput("resume_req", inst_req, 1'b1);
    checkOutput("resume_addr", inst_addr, 32'h1C00_0400);

    d_rv = 1; d_rpc = 32'h1C00_0800;
    applyStimulus();
    d_rv = 0;
    applyStimulus();
    checkOutput("redir_dok_valid", out_valid, 1'b0);
    checkOutput("redir_dok_req", inst_req, 1'b1);
    checkOutput("redir_dok_addr", inst_addr, 32'h1C00_0800);
    applyStimulus();

    d_ordy = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("stall_req", inst_req, 1'b0);
      checkOutput("stall_valid", out_valid, 1'b1);
      checkOutput("stall_pc", out_pc, 32'h1C00_0800);
    end
    d_ordy = 1;
    applyStimulus();
    checkOutput("release_req", inst_req, 1'b1);
    checkOutput("release_addr", inst_addr, 32'h1C00_0804);
    applyStimulus();
    d_ordy = 0;
    applyStimulus();
    checkOutput("held_pc", out_pc, 32'h1C00_0804);
    d_rv = 1; d_rpc = 32'h1C00_0002;
    applyStimulus();
    d_rv = 0;
    applyStimulus();
    checkOutput("redir_held_valid", out_valid, 1'b0);
    checkOutput("adef_no_req", inst_req, 1'b0);
    checkOutput("adef_addr", inst_addr, 32'h1C00_0002);
    d_ordy = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("adef_valid", out_valid, 1'b1);
      checkOutput("adef_flag", out_adef, 1'b1);
      checkOutput("adef_pc", out_pc, 32'h1C00_0002);
      checkOutput("adef_inst", out_inst, 32'h0);
      checkOutput("adef_hold_req", inst_req, 1'b0);
    end

    bp_directed = 0;
    mem_rand_lat = 1;
    for (int n = 0; n < 3000; n++) begin
      int r;
      d_rv = ($urandom_range(0, 15) == 0);
      r = int'($urandom_range(0, 15));
      if (r == 0)      d_rpc = 32'h1C00_0000 + ({22'h0, 10'($urandom_range(0, 1023))} << 2) + 32'($urandom_range(1, 3));
      else if (r == 1) d_rpc = 32'hFFFF_FFF8;
      else             d_rpc = 32'h1C00_0000 + ({22'h0, 10'($urandom_range(0, 1023))} << 2);
      d_aok  = ($urandom_range(0, 9) < 7);
      d_ordy = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    // Asynchronous reset landing in the middle of a transaction.
    d_rv = 1; d_rpc = 32'h1C00_2000; d_aok = 1; d_ordy = 1;
    applyStimulus();
    d_rv = 0;
    applyStimulus();
    applyStimulus();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", inst_req, 1'b0);
    checkOutput("midrst_addr", inst_addr, RST_PC);
    checkOutput("midrst_valid", out_valid, 1'b0);
    checkOutput("midrst_adef", out_adef, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
